cache_control: RTL

CACHE_CONTROL -- requirements
Module: cache_control

---
 rtl/cache_control.sv | 128 ++++++++++++
 1 files changed

// File: rtl/cache_control.sv
// cache_control: two-way write-back cache controller FSM with optional saturating hit/miss counters (CACHE_PERF_CTR_EN)
module cache_control (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        hit0,
  input  logic        hit1,
  input  logic        dirty0,
  input  logic        dirty1,
  input  logic        lru_out,
  input  logic        pmem_resp,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic        pmem_addr_sel,
  output logic        data_in_sel,
  output logic        load_data0,
  output logic        load_data1,
  output logic        load_tag0,
  output logic        load_tag1,
  output logic        load_valid0,
  output logic        load_valid1,
  output logic        load_dirty0,
  output logic        load_dirty1,
  output logic        dirty_in,
  output logic        load_lru,
  output logic        lru_in,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);
  typedef enum logic [1:0] {S_IDLE, S_WB, S_ALLOC} state_t;
  state_t state_q, state_d;
  logic   victim_q, victim_d;
  logic   req, hit;
  assign req = mem_read | mem_write;
  assign hit = hit0 | hit1;
  // state and latched victim way
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end
  // next state and outputs; hits answer combinationally, way0 wins ties, write wins over read
  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    data_in_sel   = 1'b0;
    load_data0    = 1'b0;
    load_data1    = 1'b0;
    load_tag0     = 1'b0;
    load_tag1     = 1'b0;
    load_valid0   = 1'b0;
    load_valid1   = 1'b0;
    load_dirty0   = 1'b0;
    load_dirty1   = 1'b0;
    dirty_in      = 1'b0;
    load_lru      = 1'b0;
    lru_in        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && hit) begin
          mem_resp    = 1'b1;
          load_lru    = 1'b1;
          lru_in      = hit0;
          dirty_in    = mem_write;
          load_data0  = mem_write & hit0;
          load_dirty0 = mem_write & hit0;
          load_data1  = mem_write & ~hit0;
          load_dirty1 = mem_write & ~hit0;
        end else if (req) begin
          victim_d = lru_out;
          state_d  = (lru_out ? dirty1 : dirty0) ? S_WB : S_ALLOC;
        end
      end
      S_WB: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        state_d       = pmem_resp ? S_ALLOC : S_WB;
      end
      S_ALLOC: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          data_in_sel = 1'b1;
          load_data0  = ~victim_q;
          load_tag0   = ~victim_q;
          load_valid0 = ~victim_q;
          load_dirty0 = ~victim_q;
          load_data1  = victim_q;
          load_tag1   = victim_q;
          load_valid1 = victim_q;
          load_dirty1 = victim_q;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
`ifdef CACHE_PERF_CTR_EN
  logic [15:0] hit_count_q, miss_count_q;
  logic        hit_inc, miss_inc;
  assign hit_inc  = (state_q == S_IDLE) & req & hit;
  assign miss_inc = (state_q == S_IDLE) & req & ~hit;
  // saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q  <= 16'h0000;
      miss_count_q <= 16'h0000;
    end else begin
      if (hit_inc && hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
      if (miss_inc && miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
    end
  end
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = 16'h0000;
  assign miss_count = 16'h0000;
`endif
endmodule
